time_unit_counter: RTL and testbench
====================================

# time_unit_counter

Parametrised modulo counter for the digital clock's seconds/minutes/hours chain; the generalised successor of the fixed seconds counter. Adds a configurable width, a run-time programmable terminal value, preset load, up/down counting and a single-cycle carry/borrow pulse. One instance per time unit; `carry` of one stage drives `tick` of the next.

## Interface
- `WIDTH`, default 7: counter and limit width in bits; legal range 2..16.
- `LIMIT_RST`, default 59: limit register value after reset; must be < 2^WIDTH.
- `clk` in 1: single clock; every register updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: block enable; low freezes `count`, ignores `tick` and `load`, forces `carry`/`load_err` to 0.
- `tick` in 1: advance request, sampled every cycle; one step per high cycle.
- `dir` in 1: 0 = count up, 1 = count down; sampled together with `tick`.
- `load` in 1: preset strobe; overrides `tick` in the same cycle.
- `load_val` in WIDTH: preset value.
- `limit_wr` in 1: limit register write strobe; honoured regardless of `en`.
- `limit_val` in WIDTH: new terminal value.
- `count` out WIDTH: current value, registered.
- `limit` out WIDTH: current limit register, registered.
- `carry` out 1: one-cycle pulse on wrap (up: limit→0; down: 0→limit).
- `load_err` out 1: one-cycle pulse when a load was clamped.

## Operation
- Reset values: `count`=0, `limit`=LIMIT_RST, `carry`=0, `load_err`=0.
- Priority per cycle: `rst` > `!en` (hold) > `load` > `tick` > hold.
- Load: if `load_val` <= `limit`, `count`←`load_val`, `load_err`←0; else `count`←`limit`, `load_err`←1. Load never asserts `carry`.
- Up tick: if `count` >= `limit`, `count`←0, `carry`←1; else `count`←`count`+1, `carry`←0.
- Down tick: if `count` == 0, `count`←`limit`, `carry`←1; else if `count` > `limit`, `count`←`limit`, `carry`←0; else `count`←`count`-1, `carry`←0.
- The `>=` on up ticks is deliberate: a limit lowered below the current count makes the next up tick wrap to 0 with carry; no tick lands above the limit.
- `limit` = 0: up or down tick keeps `count` at 0 and pulses `carry` every tick.
- Limit write: `limit`←`limit_val` at the edge; all comparisons in that same cycle use the old limit.
- Arithmetic is unsigned WIDTH-bit; the wrap compare occurs before increment, so there is no overflow at `limit` = 2^WIDTH−1.
- `carry` and `load_err` are 0 in every cycle not explicitly described above.

## Timing
- All outputs registered; latency 1 cycle from `tick`/`load`/`limit_wr` sample edge to the visible output.
- `carry` is high in the same cycle `count` shows the wrapped value (0 up, `limit` down); it drives the next stage's `tick` with no added delay, so a full chain ripples in one edge per stage level with no combinational path between stages.
- Back-to-back ticks: one step per cycle; tick high on N consecutive cycles gives N steps.
- `rst` mid-count: the next edge forces reset values; a pending `carry` is dropped.
- `en` low mid-count: value frozen; re-raising `en` resumes from the frozen value. No step is lost or duplicated.
- `load` and `tick` in the same cycle: load wins, tick discarded.

## Configuration
- `TIME_UNIT_COUNTER_BCD_EN` defined: adds output `bcd` (8 bits, tens[7:4], ones[3:0]), a registered BCD image of `count` updated in the same edge as `count`; reset 8'h00; values > 99 show 8'h99. WIDTH > 7 is still legal.
- Undefined: no `bcd` port and no conversion logic; all other behaviour identical.

## Test plan
- Reset, WIDTH=7, LIMIT_RST=59, `tick` held high 61 cycles, `dir`=0 -> counts 0..59, `count`=0 with `carry`=1 on the 60th tick, `count`=1 on the 61st.
- `dir`=1 from `count`=0, one tick -> `count`=59, `carry`=1; next tick -> 58, `carry`=0.
- `load` with `load_val`=75, limit 59 -> `count`=59, `load_err`=1 for one cycle; `load_val`=30 -> `count`=30, `load_err`=0.
- `count`=40, `limit_wr` with `limit_val`=23, then one up tick -> `count`=0, `carry`=1. Same-cycle limit write plus tick at `count`=23, old limit 59 -> `count`=24, no carry.
- `en`=0 for 5 cycles with `tick`=1 at `count`=10 -> `count` stays 10; `rst` pulse at `count`=58 with `tick` -> `count`=0, `carry`=0, `limit`=59.
- With `TIME_UNIT_COUNTER_BCD_EN`: `count`=47 -> `bcd`=8'h47; `limit`=120, `count`=105 -> `bcd`=8'h99.

Source files
------------

// File: rtl/time_unit_counter.sv
// Programmable modulo up/down counter for one stage of a seconds/minutes/hours chain.
// Define TIME_UNIT_COUNTER_BCD_EN to add a registered two-digit BCD image of count.
module time_unit_counter #(
  parameter int          WIDTH     = 7,
  parameter int unsigned LIMIT_RST = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             limit_wr,
  input  logic [WIDTH-1:0] limit_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] limit,
`ifdef TIME_UNIT_COUNTER_BCD_EN
  output logic [7:0]       bcd,
`endif
  output logic             carry,
  output logic             load_err
);

  logic [WIDTH-1:0] count_nxt, limit_nxt;
  logic             carry_nxt, err_nxt;

  // Wrap compare happens before the increment, so limit = all-ones never overflows.
  always_comb begin
    count_nxt = count;
    carry_nxt = 1'b0;
    err_nxt   = 1'b0;
    limit_nxt = limit_wr ? limit_val : limit;
    if (en) begin
      if (load) begin
        if (load_val <= limit) begin
          count_nxt = load_val;
        end else begin
          count_nxt = limit;
          err_nxt   = 1'b1;
        end
      end else if (tick) begin
        if (!dir) begin
          if (count >= limit) begin
            count_nxt = '0;
            carry_nxt = 1'b1;
          end else begin
            count_nxt = count + WIDTH'(1);
          end
        end else begin
          if (count == '0) begin
            count_nxt = limit;
            carry_nxt = 1'b1;
          end else if (count > limit) begin
            count_nxt = limit;
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      limit    <= WIDTH'(LIMIT_RST);
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      limit    <= limit_nxt;
      carry    <= carry_nxt;
      load_err <= err_nxt;
    end
  end

`ifdef TIME_UNIT_COUNTER_BCD_EN
  // Converted from count_nxt so bcd and count change on the same edge.
  function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
    int unsigned n;
    n = 32'(v);
    if (n > 99) return 8'h99;
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) bcd <= 8'h00;
    else     bcd <= to_bcd(count_nxt);
  end
`endif

endmodule

// File: tb/tb_time_unit_counter.sv
// Directed bench for time_unit_counter: wrap sequence plus a vector table of corner cases.
module tb_time_unit_counter;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst, en, tick, dir, load, limit_wr;
  logic [W-1:0] load_val, limit_val, count, limit;
  logic         carry, load_err;
`ifdef TIME_UNIT_COUNTER_BCD_EN
  logic [7:0]   bcd;
`endif

  int checks = 0;
  int errors = 0;

  time_unit_counter #(.WIDTH(W), .LIMIT_RST(59)) dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .dir(dir),
    .load(load), .load_val(load_val), .limit_wr(limit_wr), .limit_val(limit_val),
    .count(count), .limit(limit),
`ifdef TIME_UNIT_COUNTER_BCD_EN
    .bcd(bcd),
`endif
    .carry(carry), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst, en, tick, dir, load;
    logic [W-1:0] lv;
    logic         lw;
    logic [W-1:0] lmv;
    logic [W-1:0] ec, el;
    logic         ecy, eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic t, logic d, logic l, int lv,
                              logic lw, int lmv, int ec, int el, logic ecy, logic eerr);
    vec_t v;
    v.rst = r; v.en = e; v.tick = t; v.dir = d; v.load = l; v.lv = W'(lv);
    v.lw = lw; v.lmv = W'(lmv); v.ec = W'(ec); v.el = W'(el); v.ecy = ecy; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int ec, int el, int ecy, int eerr);
    chk({tag, ".count"}, int'(count), ec);
    chk({tag, ".limit"}, int'(limit), el);
    chk({tag, ".carry"}, int'(carry), ecy);
    chk({tag, ".load_err"}, int'(load_err), eerr);
`ifdef TIME_UNIT_COUNTER_BCD_EN
    chk({tag, ".bcd"}, int'(bcd), (ec > 99) ? 'h99 : ((ec / 10) * 16 + (ec % 10)));
`endif
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; tick = 1'b0; dir = 1'b0; load = 1'b0;
    load_val = '0; limit_wr = 1'b0; limit_val = '0;
    @(posedge clk); @(posedge clk); #1;
    chk_all("reset", 0, 59, 0, 0);

    // Free-running up count: 0..59, wrap with carry on tick 60, then 1.
    @(negedge clk); rst = 1'b0; tick = 1'b1; dir = 1'b0;
    for (int i = 1; i <= 61; i++) begin
      @(posedge clk); #1;
      chk($sformatf("up%0d.count", i), int'(count), i % 60);
      chk($sformatf("up%0d.carry", i), int'(carry), (i == 60) ? 1 : 0);
      @(negedge clk);
    end
    tick = 1'b0;

    //                  rst en tk dr ld lv   lw lmv  cnt lim cy er
    vecs.push_back(mk(0, 1, 0, 0, 1, 0,   0, 0,   0,  59, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,   0, 0,   59, 59, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,   0, 0,   58, 59, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 75,  0, 0,   59, 59, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0,   59, 59, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 30,  0, 0,   30, 59, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 40,  0, 0,   40, 59, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 23,  40, 23, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,   0, 0,   0,  23, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,   0, 0,   23, 23, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 50,  0, 0,   23, 23, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 59,  23, 59, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,   1, 23,  24, 23, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,   0, 0,   23, 23, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 59,  23, 59, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 10,  0, 0,   10, 59, 0, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,   10, 59, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5,   0, 0,   10, 59, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 40,  10, 40, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,   0, 0,   11, 40, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 59,  11, 59, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 57,  0, 0,   57, 59, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,   0, 0,   58, 59, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 30,  58, 30, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,   0, 0,   0,  59, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 0,   0,  0,  0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,   0, 0,   0,  0,  1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,   0, 0,   0,  0,  1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,   0, 0,   0,  0,  1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 127, 0,  127, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 126, 0, 0,   126, 127, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,   0, 0,   127, 127, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,   0, 0,   0,  127, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,   0, 0,   127, 127, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0,   127, 127, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,   0, 0,   127, 127, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 47,  0, 0,   47, 127, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 105, 0, 0,   105, 127, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 127, 0, 0,   127, 127, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; en = vecs[i].en; tick = vecs[i].tick; dir = vecs[i].dir;
      load = vecs[i].load; load_val = vecs[i].lv;
      limit_wr = vecs[i].lw; limit_val = vecs[i].lmv;
      @(posedge clk); #1;
      chk_all($sformatf("v%0d", i), int'(vecs[i].ec), int'(vecs[i].el),
              int'(vecs[i].ecy), int'(vecs[i].eerr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
